// File: rtl/capture_sequencer_if.sv
// Signal bundle between the capture sequencer and its controller/RAM side.
// The master modport drives the controls and the slave modport is the sequencer itself.
interface capture_sequencer_if;
  logic        start;
  logic        abort;
  logic        sample_valid;
  logic [7:0]  ch0;
  logic [7:0]  ch1;
  logic [7:0]  ch2;
  logic [7:0]  ch3;
  logic [7:0]  threshold;
  logic [11:0] rd_addr;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [10:0] frame_count;

  modport master (
    output start, abort, sample_valid, ch0, ch1, ch2, ch3, threshold, rd_addr,
    input  ram_addr, ram_data, ram_wren, busy, done, overrun, frame_count
  );

  modport slave (
    input  start, abort, sample_valid, ch0, ch1, ch2, ch3, threshold, rd_addr,
    output ram_addr, ram_data, ram_wren, busy, done, overrun, frame_count
  );
endinterface

// File: rtl/capture_sequencer.sv
// Captures 4-channel ADC frames into a RAM as 4-beat write bursts.
// Optional macro TRIGGER_EN adds an ARMED state that waits for a rising crossing of threshold on ch0.
module capture_sequencer #(
  parameter int FRAMES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  capture_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
`ifdef TRIGGER_EN
  localparam logic [2:0] ST_ARMED = 3'd1;
`endif
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [10:0] FRAMES_C = 11'(FRAMES);

  logic [2:0]  state_q, state_d;
  logic [10:0] frame_count_q, frame_count_d;
  logic        overrun_q, overrun_d;
  logic [1:0]  beat_q, beat_d;
  logic [7:0]  ch_q [4];
  logic [7:0]  ch_d [4];
  logic [10:0] frame_inc;
  logic        writing;

`ifdef TRIGGER_EN
  logic [7:0]  prev_q, prev_d;
  logic        prev_valid_q, prev_valid_d;
  logic        crossing;

  assign crossing = prev_valid_q && (prev_q < bus.threshold) && (bus.ch0 >= bus.threshold);
`else
  logic        unused_threshold;

  assign unused_threshold = ^bus.threshold;
`endif

  assign frame_inc = frame_count_q + 11'd1;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    beat_d        = beat_q;
    ch_d          = ch_q;
`ifdef TRIGGER_EN
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // abort beats a coincident start, even where abort itself has no effect
        if (bus.start && !bus.abort) begin
          frame_count_d = '0;
          overrun_d     = 1'b0;
`ifdef TRIGGER_EN
          prev_valid_d  = 1'b0;
          state_d       = ST_ARMED;
`else
          state_d       = ST_WAIT;
`endif
        end
      end

`ifdef TRIGGER_EN
      ST_ARMED: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.sample_valid) begin
          prev_d       = bus.ch0;
          prev_valid_d = 1'b1;
          if (crossing) begin
            ch_d    = '{bus.ch0, bus.ch1, bus.ch2, bus.ch3};
            beat_d  = 2'd0;
            state_d = ST_WRITE;
          end
        end
      end
`endif

      ST_WAIT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.sample_valid) begin
          ch_d    = '{bus.ch0, bus.ch1, bus.ch2, bus.ch3};
          beat_d  = 2'd0;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          if (bus.sample_valid) overrun_d = 1'b1;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            frame_count_d = frame_inc;
            state_d       = (frame_inc == FRAMES_C) ? ST_DONE : ST_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      beat_q        <= '0;
      // NOTE: the frame registers are small and directly drive ram_data, so they are cleared on reset.
      ch_q          <= '{default: '0};
`ifdef TRIGGER_EN
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      beat_q        <= beat_d;
      ch_q          <= ch_d;
`ifdef TRIGGER_EN
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
`endif
    end
  end

  // Outputs are decoded from registered state, so an abort or reset removes ram_wren one cycle later.
  assign writing         = (state_q == ST_WRITE);
  assign bus.ram_wren    = writing;
  assign bus.ram_addr    = writing ? {frame_count_q[9:0], beat_q} : bus.rd_addr;
  assign bus.ram_data    = writing ? ch_q[beat_q] : 8'd0;
`ifdef TRIGGER_EN
  assign bus.busy        = (state_q == ST_ARMED) || (state_q == ST_WAIT) || writing;
`else
  assign bus.busy        = (state_q == ST_WAIT) || writing;
`endif
  assign bus.done        = (state_q == ST_DONE);
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: dut_a (FRAMES=2) and dut_b (FRAMES=1024) share one stimulus.
// Works in both builds; the threshold-crossing scenario is selected by TRIGGER_EN.
module tb_capture_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  capture_sequencer_if bus_a ();
  capture_sequencer_if bus_b ();

  capture_sequencer #(.FRAMES(2))    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  capture_sequencer #(.FRAMES(1024)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.start        = bus_a.start;
  assign bus_b.abort        = bus_a.abort;
  assign bus_b.sample_valid = bus_a.sample_valid;
  assign bus_b.ch0          = bus_a.ch0;
  assign bus_b.ch1          = bus_a.ch1;
  assign bus_b.ch2          = bus_a.ch2;
  assign bus_b.ch3          = bus_a.ch3;
  assign bus_b.threshold    = bus_a.threshold;
  assign bus_b.rd_addr      = bus_a.rd_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic sample(input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3);
    bus_a.ch0 = c0;
    bus_a.ch1 = c1;
    bus_a.ch2 = c2;
    bus_a.ch3 = c3;
    bus_a.sample_valid = 1'b1;
    tick();
    bus_a.sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  // With the trigger built in, a low ch0 sample primes prev so the next frame crosses threshold=1.
  task automatic prime();
`ifdef TRIGGER_EN
    sample(8'd0, 8'd0, 8'd0, 8'd0);
    check("prime_no_write", bus_a.ram_wren, 0);
`endif
  endtask

  task automatic burst(input logic [11:0] base, input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3, input bit check_a);
    logic [7:0] d [4];
    d = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) begin
      check("wren_b", bus_b.ram_wren, 1);
      check("addr_b", bus_b.ram_addr, 32'(base) + 32'(k));
      check("data_b", bus_b.ram_data, d[k]);
      if (check_a) begin
        check("wren_a", bus_a.ram_wren, 1);
        check("addr_a", bus_a.ram_addr, 32'(base) + 32'(k));
        check("data_a", bus_a.ram_data, d[k]);
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_a.sample_valid = 1'b0;
    bus_a.ch0 = '0;
    bus_a.ch1 = '0;
    bus_a.ch2 = '0;
    bus_a.ch3 = '0;
    bus_a.threshold = 8'd1;
    bus_a.rd_addr = 12'h5A5;

    // Reset state
    do_reset();
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_overrun", bus_a.overrun, 0);
    check("rst_wren", bus_a.ram_wren, 0);
    check("rst_data", bus_a.ram_data, 0);
    check("rst_fcount", bus_a.frame_count, 0);
    check("rst_addr", bus_a.ram_addr, 12'h5A5);

    // Scenario 1: two frames into a FRAMES=2 capture
    pulse_start();
    check("s1_busy", bus_a.busy, 1);
    prime();
    sample(8'd11, 8'd22, 8'd33, 8'd44);
    burst(12'd0, 8'd11, 8'd22, 8'd33, 8'd44, 1'b1);
    check("s1_gap_wren", bus_a.ram_wren, 0);
    check("s1_gap_addr", bus_a.ram_addr, 12'h5A5);
    check("s1_gap_data", bus_a.ram_data, 0);
    check("s1_fcount1", bus_a.frame_count, 1);
    sample(8'd55, 8'd66, 8'd77, 8'd88);
    burst(12'd4, 8'd55, 8'd66, 8'd77, 8'd88, 1'b1);
    check("s1_done", bus_a.done, 1);
    check("s1_busy_end", bus_a.busy, 0);
    check("s1_fcount2", bus_a.frame_count, 2);
    check("s1_b_busy", bus_b.busy, 1);
    check("s1_b_fcount", bus_b.frame_count, 2);
    tick();
    check("s1_done_hold", bus_a.done, 1);

    // Scenario 2: sample_valid two cycles after an accepted one overruns
    do_reset();
    pulse_start();
    prime();
    sample(8'd1, 8'd2, 8'd3, 8'd4);
    check("s2_w0", bus_a.ram_addr, 0);
    tick();
    bus_a.sample_valid = 1'b1;
    bus_a.ch0 = 8'd99;
    tick();
    bus_a.sample_valid = 1'b0;
    check("s2_overrun", bus_a.overrun, 1);
    check("s2_w2_addr", bus_a.ram_addr, 2);
    check("s2_w2_data", bus_a.ram_data, 3);
    tick();
    check("s2_w3_data", bus_a.ram_data, 4);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("s2_no_write", bus_a.ram_wren, 0);
      tick();
    end
    check("s2_fcount", bus_a.frame_count, 1);
    pulse_start();
    check("s2_start_busy_ovr", bus_a.overrun, 1);
    check("s2_start_busy_fc", bus_a.frame_count, 1);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("s2_abort_busy", bus_a.busy, 0);
    check("s2_abort_ovr", bus_a.overrun, 1);
    pulse_start();
    check("s2_restart_ovr", bus_a.overrun, 0);
    check("s2_restart_fc", bus_a.frame_count, 0);

`ifdef TRIGGER_EN
    // Scenario 3: rising crossing of threshold=128 on ch0
    do_reset();
    bus_a.threshold = 8'd128;
    pulse_start();
    check("s3_armed_busy", bus_a.busy, 1);
    sample(8'd200, 8'd1, 8'd1, 8'd1);
    check("s3_200", bus_a.ram_wren, 0);
    sample(8'd100, 8'd1, 8'd1, 8'd1);
    check("s3_100", bus_a.ram_wren, 0);
    sample(8'd127, 8'd1, 8'd1, 8'd1);
    check("s3_127", bus_a.ram_wren, 0);
    sample(8'd130, 8'd5, 8'd6, 8'd7);
    burst(12'd0, 8'd130, 8'd5, 8'd6, 8'd7, 1'b1);
    check("s3_fcount", bus_a.frame_count, 1);
    bus_a.threshold = 8'd1;
`else
    // Threshold has no effect without the trigger: a frame below it is written at once
    do_reset();
    bus_a.threshold = 8'd200;
    pulse_start();
    sample(8'd5, 8'd6, 8'd7, 8'd8);
    burst(12'd0, 8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
    bus_a.threshold = 8'd1;
`endif

    // Scenario 4: abort in the second WRITE cycle of frame 1
    do_reset();
    pulse_start();
    prime();
    sample(8'd9, 8'd8, 8'd7, 8'd6);
    burst(12'd0, 8'd9, 8'd8, 8'd7, 8'd6, 1'b1);
    sample(8'd19, 8'd18, 8'd17, 8'd16);
    tick();
    bus_a.abort = 1'b1;
    check("s4_w1_wren", bus_a.ram_wren, 1);
    check("s4_w1_addr", bus_a.ram_addr, 5);
    tick();
    bus_a.abort = 1'b0;
    check("s4_wren", bus_a.ram_wren, 0);
    check("s4_busy", bus_a.busy, 0);
    check("s4_done", bus_a.done, 0);
    check("s4_fcount", bus_a.frame_count, 1);
    check("s4_addr", bus_a.ram_addr, 12'h5A5);
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    check("s4_sa_busy", bus_a.busy, 0);
    check("s4_sa_fcount", bus_a.frame_count, 1);
    tick();
    check("s4_sa_wren", bus_a.ram_wren, 0);

    // Scenario 6: reset in the middle of WRITE
    do_reset();
    pulse_start();
    prime();
    sample(8'd50, 8'd51, 8'd52, 8'd53);
    tick();
    reset = 1'b1;
    bus_a.start = 1'b1;
    tick();
    reset = 1'b0;
    bus_a.start = 1'b0;
    check("s6_wren", bus_a.ram_wren, 0);
    check("s6_busy", bus_a.busy, 0);
    check("s6_done", bus_a.done, 0);
    check("s6_overrun", bus_a.overrun, 0);
    check("s6_data", bus_a.ram_data, 0);
    check("s6_fcount", bus_a.frame_count, 0);
    check("s6_addr", bus_a.ram_addr, 12'h5A5);
    tick();
    check("s6_wren_later", bus_a.ram_wren, 0);
    check("s6_busy_later", bus_a.busy, 0);

    // Scenario 5: full 1024-frame capture on dut_b
    do_reset();
    pulse_start();
    prime();
    for (int f = 0; f < 1024; f++) begin
      sample(8'(4 * f + 1), 8'(4 * f + 2), 8'(4 * f + 3), 8'(4 * f + 4));
      burst(12'(4 * f), 8'(4 * f + 1), 8'(4 * f + 2), 8'(4 * f + 3), 8'(4 * f + 4), f < 2);
      if (f == 1) check("s5_a_done", bus_a.done, 1);
    end
    check("s5_done", bus_b.done, 1);
    check("s5_busy", bus_b.busy, 0);
    check("s5_fcount", bus_b.frame_count, 1024);
    check("s5_a_fcount", bus_a.frame_count, 2);
    bus_a.rd_addr = 12'd100;
    #1;
    check("s5_rd_addr", bus_b.ram_addr, 100);
    check("s5_rd_wren", bus_b.ram_wren, 0);
    check("s5_rd_data", bus_b.ram_data, 0);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("s5_abort_done", bus_b.done, 1);
    tick();
    check("s5_done_hold", bus_b.done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
